// File: rtl/axil_reg_slice.sv
// axil_reg_slice: AXI4-Lite register slice with per-channel buffers, outstanding limits and counters
// Ports: s_* face the upstream master (AW/W/AR in, B/R out); m_* mirror them toward the register-file slave;
//        wr_outstanding/rd_outstanding count transactions accepted on AW/AR whose response has not gone upstream.
module axil_reg_slice_buf #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] push_data,
  input  logic         push_valid,
  output logic         push_ready,
  output logic [W-1:0] pop_data,
  output logic         pop_valid,
  input  logic         pop_ready
);
  if (DEPTH == 0) begin : g_pass
    assign pop_data   = push_data;
    assign pop_valid  = push_valid;
    assign push_ready = pop_ready;
  end else begin : g_fifo
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop;
    // ready comes from the count register alone, so a full buffer stays not-ready in its pop cycle
    assign push_ready = cnt_q < FULL;
    assign pop_valid  = cnt_q != '0;
    assign pop_data   = mem_q[rd_q];
    always_comb begin
      push  = push_valid && push_ready;
      pop   = pop_valid && pop_ready;
      mem_d = mem_q;
      if (push) mem_d[wr_q] = push_data;
      wr_d  = push ? (wr_q == LAST ? '0 : wr_q + 1'b1) : wr_q;
      rd_d  = pop ? (rd_q == LAST ? '0 : rd_q + 1'b1) : rd_q;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q <= '{default: '0};
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        mem_q <= mem_d;
        rd_q  <= rd_d;
        wr_q  <= wr_d;
        cnt_q <= cnt_d;
      end
    end
  end
endmodule

module axil_reg_slice #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int AW_DEPTH   = 2,
  parameter int W_DEPTH    = 2,
  parameter int B_DEPTH    = 2,
  parameter int AR_DEPTH   = 2,
  parameter int R_DEPTH    = 2,
  parameter int MAX_WR_OUT = 4,
  parameter int MAX_RD_OUT = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB_WIDTH-1:0] s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [STRB_WIDTH-1:0] m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic [CNT_WIDTH-1:0]  wr_outstanding,
  output logic [CNT_WIDTH-1:0]  rd_outstanding
);
  localparam logic [CNT_WIDTH-1:0] WR_MAX = CNT_WIDTH'(MAX_WR_OUT);
  localparam logic [CNT_WIDTH-1:0] RD_MAX = CNT_WIDTH'(MAX_RD_OUT);
  logic                 aw_push_ready, ar_push_ready, wr_ok, rd_ok;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

  function automatic logic [CNT_WIDTH-1:0] step_cnt(logic [CNT_WIDTH-1:0] c, logic inc, logic dec);
    return (inc && !dec) ? (&c ? c : c + 1'b1) : (!inc && dec) ? (c == '0 ? c : c - 1'b1) : c;
  endfunction

  // the limit gates both the upstream ready and the buffer push so a blocked beat is never stored
  assign wr_ok     = (MAX_WR_OUT == 0) || (wr_cnt_q < WR_MAX);
  assign rd_ok     = (MAX_RD_OUT == 0) || (rd_cnt_q < RD_MAX);
  assign s_awready = aw_push_ready && wr_ok;
  assign s_arready = ar_push_ready && rd_ok;
  assign wr_outstanding = wr_cnt_q;
  assign rd_outstanding = rd_cnt_q;

  always_comb begin
    wr_cnt_d = step_cnt(wr_cnt_q, s_awvalid && s_awready, s_bvalid && s_bready);
    rd_cnt_d = step_cnt(rd_cnt_q, s_arvalid && s_arready, s_rvalid && s_rready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  axil_reg_slice_buf #(.DEPTH(AW_DEPTH), .W(ADDR_WIDTH)) u_aw (
    .clk(clk), .rst_n(rst_n),
    .push_data(s_awaddr), .push_valid(s_awvalid && wr_ok), .push_ready(aw_push_ready),
    .pop_data(m_awaddr), .pop_valid(m_awvalid), .pop_ready(m_awready)
  );

  axil_reg_slice_buf #(.DEPTH(W_DEPTH), .W(DATA_WIDTH + STRB_WIDTH)) u_w (
    .clk(clk), .rst_n(rst_n),
    .push_data({s_wdata, s_wstrb}), .push_valid(s_wvalid), .push_ready(s_wready),
    .pop_data({m_wdata, m_wstrb}), .pop_valid(m_wvalid), .pop_ready(m_wready)
  );

  axil_reg_slice_buf #(.DEPTH(B_DEPTH), .W(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .push_data(m_bresp), .push_valid(m_bvalid), .push_ready(m_bready),
    .pop_data(s_bresp), .pop_valid(s_bvalid), .pop_ready(s_bready)
  );

  axil_reg_slice_buf #(.DEPTH(AR_DEPTH), .W(ADDR_WIDTH)) u_ar (
    .clk(clk), .rst_n(rst_n),
    .push_data(s_araddr), .push_valid(s_arvalid && rd_ok), .push_ready(ar_push_ready),
    .pop_data(m_araddr), .pop_valid(m_arvalid), .pop_ready(m_arready)
  );

  axil_reg_slice_buf #(.DEPTH(R_DEPTH), .W(DATA_WIDTH + 2)) u_r (
    .clk(clk), .rst_n(rst_n),
    .push_data({m_rdata, m_rresp}), .push_valid(m_rvalid), .push_ready(m_rready),
    .pop_data({s_rdata, s_rresp}), .pop_valid(s_rvalid), .pop_ready(s_rready)
  );
endmodule

// File: tb/tb_axil_reg_slice.sv
// tb_axil_reg_slice: scoreboard bench for axil_reg_slice with mixed buffer depths and random traffic
module tb_axil_reg_slice;
  localparam int AWD = 2, WD = 1, BD = 0, ARD = 2, RD = 3, MAXW = 8, MAXR = 2;
  logic        clk = 0, rst_n = 0;
  logic [31:0] s_awaddr, m_awaddr, s_araddr, m_araddr, s_wdata, m_wdata, s_rdata, m_rdata;
  logic [3:0]  s_wstrb, m_wstrb;
  logic [1:0]  s_bresp, m_bresp, s_rresp, m_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic [7:0]  wr_outstanding, rd_outstanding;
  int vectors = 0, miscompares = 0;
  int k_aw, k_w, k_ar, k_bready, k_rready, k_mawr, k_mwr, k_marr, k_mb, k_mr, w_lead;
  bit seq;
  int aw_acc, w_acc, ar_acc, aw_got, w_got, ar_got, b_iss, r_iss;

  always #5 clk = ~clk;

  axil_reg_slice #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4),
    .AW_DEPTH(AWD), .W_DEPTH(WD), .B_DEPTH(BD), .AR_DEPTH(ARD), .R_DEPTH(RD),
    .MAX_WR_OUT(MAXW), .MAX_RD_OUT(MAXR), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
  );

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic bit pr(int k);
    return $urandom_range(99) < k;
  endfunction

  // Reference model: each buffer is an ordered queue of accepted-but-not-delivered beats;
  // outstanding counts are accepted requests minus returned responses, floored at zero.
  logic [31:0] awq[$], arq[$];
  logic [35:0] wq[$];
  logic [33:0] rq[$];
  int wcnt, rcnt;
  always @(negedge clk) begin
    if (!rst_n) begin
      awq.delete(); arq.delete(); wq.delete(); rq.delete();
      wcnt = 0; rcnt = 0;
    end else begin
      chk("aw_ready", s_awready, awq.size() < AWD && wcnt < MAXW);
      chk("aw_valid", m_awvalid, awq.size() != 0);
      chk("w_ready", s_wready, wq.size() < WD);
      chk("w_valid", m_wvalid, wq.size() != 0);
      chk("b_valid", s_bvalid, m_bvalid);
      chk("b_ready", m_bready, s_bready);
      chk("ar_ready", s_arready, arq.size() < ARD && rcnt < MAXR);
      chk("ar_valid", m_arvalid, arq.size() != 0);
      chk("r_ready", m_rready, rq.size() < RD);
      chk("r_valid", s_rvalid, rq.size() != 0);
      chk("wr_out", wr_outstanding, wcnt);
      chk("rd_out", rd_outstanding, rcnt);
      if (s_awvalid && s_awready) awq.push_back(s_awaddr);
      if (s_wvalid && s_wready) wq.push_back({s_wdata, s_wstrb});
      if (s_arvalid && s_arready) arq.push_back(s_araddr);
      if (m_rvalid && m_rready) rq.push_back({m_rdata, m_rresp});
      if (m_awvalid && m_awready) begin
        if (awq.size() == 0) chk("aw_extra", 1, 0); else chk("aw_addr", m_awaddr, awq.pop_front());
      end
      if (m_wvalid && m_wready) begin
        if (wq.size() == 0) chk("w_extra", 1, 0); else chk("w_beat", {m_wdata, m_wstrb}, wq.pop_front());
      end
      if (m_arvalid && m_arready) begin
        if (arq.size() == 0) chk("ar_extra", 1, 0); else chk("ar_addr", m_araddr, arq.pop_front());
      end
      if (s_rvalid && s_rready) begin
        if (rq.size() == 0) chk("r_extra", 1, 0); else chk("r_beat", {s_rdata, s_rresp}, rq.pop_front());
      end
      if (s_bvalid) chk("b_resp", s_bresp, m_bresp);
      wcnt += int'(s_awvalid && s_awready) - int'(s_bvalid && s_bready);
      rcnt += int'(s_arvalid && s_arready) - int'(s_rvalid && s_rready);
      if (wcnt < 0) wcnt = 0;
      if (rcnt < 0) rcnt = 0;
    end
  end

  task automatic clear_drive();
    {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready, m_awready, m_wready, m_arready, m_bvalid, m_rvalid} = '0;
    {s_awaddr, s_araddr, s_wdata, m_rdata} = '0;
    {s_wstrb, m_bresp, m_rresp} = '0;
    {k_aw, k_w, k_ar, k_bready, k_rready, k_mawr, k_mwr, k_marr, k_mb, k_mr, w_lead} = '0;
    {aw_acc, w_acc, ar_acc, aw_got, w_got, ar_got, b_iss, r_iss} = '0;
    seq = 0;
  endtask

  // one clock: observe handshakes of the closing cycle, then drive the next one (valids hold until taken);
  // the downstream slave returns one B per AW/W pair and one R per AR it has seen
  task automatic step();
    bit aw_hs, w_hs, ar_hs, mb_hs, mr_hs;
    @(posedge clk);
    aw_hs = s_awvalid && s_awready;
    w_hs  = s_wvalid && s_wready;
    ar_hs = s_arvalid && s_arready;
    mb_hs = m_bvalid && m_bready;
    mr_hs = m_rvalid && m_rready;
    aw_got += int'(m_awvalid && m_awready);
    w_got  += int'(m_wvalid && m_wready);
    ar_got += int'(m_arvalid && m_arready);
    b_iss  += int'(mb_hs);
    r_iss  += int'(mr_hs);
    aw_acc += int'(aw_hs);
    w_acc  += int'(w_hs);
    ar_acc += int'(ar_hs);
    #1;
    if (!s_awvalid || aw_hs) begin
      s_awvalid = pr(k_aw);
      s_awaddr  = seq ? 32'(aw_acc * 4) : $urandom;
    end
    if (!s_wvalid || w_hs) begin
      s_wvalid = pr(k_w) && w_acc < aw_acc + w_lead;
      s_wdata  = $urandom;
      s_wstrb  = seq ? 4'hF : 4'($urandom);
    end
    if (!s_arvalid || ar_hs) begin
      s_arvalid = pr(k_ar);
      s_araddr  = seq ? 32'h100 + 32'(ar_acc * 4) : $urandom;
    end
    if (!m_bvalid || mb_hs) begin
      m_bvalid = pr(k_mb) && b_iss < aw_got && b_iss < w_got;
      m_bresp  = 2'($urandom);
    end
    if (!m_rvalid || mr_hs) begin
      m_rvalid = pr(k_mr) && r_iss < ar_got;
      m_rdata  = $urandom;
      m_rresp  = 2'($urandom);
    end
    s_bready  = pr(k_bready);
    s_rready  = pr(k_rready);
    m_awready = pr(k_mawr);
    m_wready  = pr(k_mwr);
    m_arready = pr(k_marr);
  endtask

  initial begin
    clear_drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", s_awready, 1);
    chk("rst_wready", s_wready, 1);
    chk("rst_arready", s_arready, 1);
    chk("rst_rready", m_rready, 1);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_wr_out", wr_outstanding, 0);
    chk("rst_rd_out", rd_outstanding, 0);
    rst_n = 1;
    // AW stream: 8 sequential addresses fill the write limit, the 9th stalls
    seq = 1; k_aw = 100; k_mawr = 100;
    repeat (10) step();
    chk("aw_stream_cnt", wr_outstanding, 8);
    chk("aw_stream_stall", s_awready, 0);
    chk("aw_delivered", aw_got, 8);
    // half-rate W (strobe 0xF), B pass-through; AW keeps pressing so AW and B handshakes coincide
    k_w = 100; k_mwr = 100; k_mb = 100; k_bready = 100;
    repeat (40) step();
    k_aw = 0;
    repeat (40) step();
    chk("wr_drained", wr_outstanding, 0);
    // AR backpressure then outstanding limit with R withheld
    k_ar = 100; k_marr = 0;
    repeat (6) step();
    chk("ar_bp_ready", s_arready, 0);
    chk("ar_bp_cnt", rd_outstanding, 2);
    chk("ar_bp_head", m_araddr, 32'h100);
    k_marr = 100;
    repeat (6) step();
    chk("ar_lim_ready", s_arready, 0);
    chk("ar_lim_cnt", rd_outstanding, 2);
    chk("ar_lim_sent", ar_got, 2);
    k_mr = 100; k_rready = 100;
    repeat (20) step();
    k_ar = 0;
    repeat (20) step();
    chk("rd_drained", rd_outstanding, 0);
    // reset while two R beats sit in the buffer
    seq = 0; k_ar = 100; k_rready = 0;
    repeat (10) step();
    chk("pre_rst_rvalid", s_rvalid, 1);
    chk("pre_rst_rd_out", rd_outstanding, 2);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_rvalid", s_rvalid, 0);
    chk("mid_rst_rd_out", rd_outstanding, 0);
    chk("mid_rst_wr_out", wr_outstanding, 0);
    chk("mid_rst_rready", m_rready, 1);
    chk("mid_rst_arvalid", m_arvalid, 0);
    clear_drive();
    @(negedge clk);
    #1 rst_n = 1;
    // random traffic on every channel
    w_lead = 2;
    for (int i = 0; i < 20; i++) begin
      k_aw = $urandom_range(20, 100); k_w = $urandom_range(20, 100); k_ar = $urandom_range(20, 100);
      k_bready = $urandom_range(20, 100); k_rready = $urandom_range(20, 100);
      k_mawr = $urandom_range(20, 100); k_mwr = $urandom_range(20, 100); k_marr = $urandom_range(20, 100);
      k_mb = $urandom_range(20, 100); k_mr = $urandom_range(20, 100);
      repeat (100) step();
    end
    k_aw = 0; k_ar = 0; k_w = 100; w_lead = 0;
    k_bready = 100; k_rready = 100; k_mawr = 100; k_mwr = 100; k_marr = 100; k_mb = 100; k_mr = 100;
    repeat (100) step();
    chk("end_wr_out", wr_outstanding, 0);
    chk("end_rd_out", rd_outstanding, 0);
    chk("end_bvalid", s_bvalid, 0);
    chk("end_rvalid", s_rvalid, 0);
    chk("end_awvalid", m_awvalid, 0);
    chk("end_arvalid", m_arvalid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
